// File: rtl/image_load_if.sv
`default_nettype none
// ============================================================================
// Module      : image_load_if
// Description : UART-byte / image-RAM / CNN handshake bundle for the image
//               load controller. master = controller side, slave = system side.
// Revision    : 1.0 - initial release
// ============================================================================
interface image_load_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              cnn_start;
  logic              cnn_done;
  logic              busy;
  logic              loading;
  logic [7:0]        frame_count;
  logic              timeout_err;
  logic              overrun_err;

  modport master (
    input  rx_data, rx_valid, cnn_done,
    output wr_addr, wr_data, wr_en, cnn_start, busy, loading,
           frame_count, timeout_err, overrun_err
  );

  modport slave (
    output rx_data, rx_valid, cnn_done,
    input  wr_addr, wr_data, wr_en, cnn_start, busy, loading,
           frame_count, timeout_err, overrun_err
  );
endinterface
`default_nettype wire

// File: rtl/image_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : image_load_ctrl
// Description : Writes one NUM_PIXELS-byte image from the UART byte stream into
//               the image RAM, then hands it to the CNN and locks the loader
//               out until the CNN reports done. Partial frames are dropped
//               after an inter-byte idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module image_load_ctrl #(
  parameter int NUM_PIXELS     = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input wire          clk,
  input wire          rst,
  image_load_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              cnn_start_q, cnn_start_d;
  logic              busy_q, busy_d;
  logic              loading_q, loading_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_err_q, overrun_err_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    to_cnt_d      = to_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    cnn_start_d   = 1'b0;
    busy_d        = busy_q;
    loading_d     = 1'b0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    overrun_err_d = overrun_err_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        to_cnt_d = '0;
        busy_d   = 1'b0;
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = bus.rx_data;
          cnt_d     = ADDR_W'(1);
          loading_d = 1'b1;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        loading_d = 1'b1;
        if (bus.rx_valid) begin
          // A byte in the final idle cycle still wins over the timeout.
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = bus.rx_data;
          to_cnt_d  = '0;
          if (cnt_q == LAST_ADDR) begin
            cnt_d     = '0;
            loading_d = 1'b0;
            state_d   = START;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Stale partial frame: drop it; RAM contents are left as-is.
          cnt_d         = '0;
          to_cnt_d      = '0;
          timeout_err_d = 1'b1;
          loading_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      START: begin
        // One cycle after the last write, so the final byte is in RAM first.
        cnn_start_d   = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        busy_d        = 1'b1;
        timeout_err_d = 1'b0;
        if (bus.rx_valid) overrun_err_d = 1'b1;
        state_d       = BUSY;
      end

      BUSY: begin
        if (bus.rx_valid) overrun_err_d = 1'b1;
        if (bus.cnn_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      to_cnt_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      cnn_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      loading_q     <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      to_cnt_q      <= to_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cnn_start_q   <= cnn_start_d;
      busy_q        <= busy_d;
      loading_q     <= loading_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.cnn_start   = cnn_start_q;
  assign bus.busy        = busy_q;
  assign bus.loading     = loading_q;
  assign bus.frame_count = frame_count_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overrun_err = overrun_err_q;

endmodule
`default_nettype wire
